// File: rtl/memory_block_pkg.sv
// Shared constants for the memory stage: opcodes, load/store funct3 codes,
// FSM state encoding and access-size helpers.
package memory_block_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LD  = 3'd3;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_LWU = 3'd6;

  localparam logic [2:0] F3_SB = 3'd0;
  localparam logic [2:0] F3_SH = 3'd1;
  localparam logic [2:0] F3_SW = 3'd2;
  localparam logic [2:0] F3_SD = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // funct3[1:0] encodes log2(bytes) for every defined load and store.
  function automatic logic [7:0] size_strobe(input logic [1:0] size);
    logic [7:0] strobe;
    case (size)
      2'd0:    strobe = 8'h01;
      2'd1:    strobe = 8'h03;
      2'd2:    strobe = 8'h0F;
      default: strobe = 8'hFF;
    endcase
    return strobe;
  endfunction

endpackage

// File: rtl/memory_block_if.sv
// Data-memory bus between memory_block (master) and the memory (slave).
interface memory_block_if;

  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [63:0] dmem_addr_o;
  logic [63:0] dmem_wdata_o;
  logic [7:0]  dmem_wstrb_o;
  logic        dmem_ack_i;
  logic [63:0] dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_wstrb_o,
    input  dmem_ack_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_wstrb_o,
    output dmem_ack_i, dmem_rdata_i
  );

endinterface

// File: rtl/mem_align.sv
// Load lane selection: shifts the read doubleword down by the byte offset and
// sign- or zero-extends the selected width according to funct3.
module mem_align
  import memory_block_pkg::*;
(
  input  logic [63:0] rdata_i,
  input  logic [2:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [63:0] data_o
);

  logic [63:0] w_shifted;

  assign w_shifted = rdata_i >> {offset_i, 3'b000};

  // NOTE: data_o gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    data_o = '0;
    case (funct3_i)
      F3_LB:   data_o = {{56{w_shifted[7]}},  w_shifted[7:0]};
      F3_LH:   data_o = {{48{w_shifted[15]}}, w_shifted[15:0]};
      F3_LW:   data_o = {{32{w_shifted[31]}}, w_shifted[31:0]};
      F3_LD:   data_o = w_shifted;
      F3_LBU:  data_o = {56'd0, w_shifted[7:0]};
      F3_LHU:  data_o = {48'd0, w_shifted[15:0]};
      F3_LWU:  data_o = {32'd0, w_shifted[31:0]};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/memory_block.sv
// Memory stage: accepts one instruction at a time, performs at most one data
// access with timeout, and emits a registered writeback bundle.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (trap misaligned accesses).
module memory_block
  import memory_block_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [63:0]    pc_i,
  input  logic           pc_i_valid,
  input  logic [31:0]    inst_i,
  input  logic           inst_i_valid,
  input  logic [63:0]    rdata_i,
  input  logic           rdata_i_valid,
  input  logic [63:0]    wdata_i,
  input  logic           wdata_i_valid,
  output logic           busy_o,
  memory_block_if.master dmem,
  output logic [63:0]    pc_o,
  output logic [31:0]    inst_o,
  output logic [63:0]    wb_data_o,
  output logic           wb_valid_o,
  output logic           err_o
);

  state_e      r_state;
  logic        r_busy;
  logic        r_req;
  logic        r_we;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [7:0]  r_wstrb;
  logic [63:0] r_cnt;
  logic [63:0] r_pc;
  logic [31:0] r_inst;
  logic        r_is_load;
  logic [2:0]  r_funct3;
  logic [2:0]  r_offset;
  logic [63:0] r_result;
  logic        r_result_err;
  logic [63:0] r_pc_o;
  logic [31:0] r_inst_o;
  logic [63:0] r_wb_data;
  logic        r_wb_valid;
  logic        r_err;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_mem;
  logic [2:0]  w_funct3;
  logic        w_f3_ok;
  logic [1:0]  w_size;
  logic [2:0]  w_low;
  logic [2:0]  w_offset;
  logic        w_misaligned;
  logic [7:0]  w_wstrb;
  logic [63:0] w_wdata;
  logic        w_accept;
  logic        w_timeout;
  logic [63:0] w_load_data;

  always_comb begin
    w_is_load  = (inst_i[6:0] == OP_LOAD);
    w_is_store = (inst_i[6:0] == OP_STORE);
    w_is_mem   = w_is_load | w_is_store;
    w_funct3   = inst_i[14:12];
    w_f3_ok    = w_is_load ? (w_funct3 != 3'd7) : !w_funct3[2];
    w_size     = w_funct3[1:0];
    w_low      = 3'((4'd1 << w_size) - 4'd1);
`ifdef MEM_MISALIGN_TRAP_EN
    w_misaligned = |(rdata_i[2:0] & w_low);
    w_offset     = rdata_i[2:0];
`else
    // Without the trap, the address is rounded down to the access size.
    w_misaligned = 1'b0;
    w_offset     = rdata_i[2:0] & ~w_low;
`endif
    w_wstrb   = size_strobe(w_size) << w_offset;
    w_wdata   = wdata_i << {w_offset, 3'b000};
    w_accept  = pc_i_valid & inst_i_valid & rdata_i_valid & wdata_i_valid &
                !r_busy & (r_state == ST_IDLE);
    w_timeout = (r_cnt == 64'(TIMEOUT_CYCLES) - 64'd1);
  end

  mem_align u_mem_align (
    .rdata_i  (dmem.dmem_rdata_i),
    .offset_i (r_offset),
    .funct3_i (r_funct3),
    .data_o   (w_load_data)
  );

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_busy       <= 1'b0;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_cnt        <= '0;
      r_pc         <= '0;
      r_inst       <= '0;
      r_is_load    <= 1'b0;
      r_funct3     <= '0;
      r_offset     <= '0;
      r_result     <= '0;
      r_result_err <= 1'b0;
      r_pc_o       <= '0;
      r_inst_o     <= '0;
      r_wb_data    <= '0;
      r_wb_valid   <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_busy       <= 1'b1;
            r_pc         <= pc_i;
            r_inst       <= inst_i;
            r_is_load    <= w_is_load;
            r_funct3     <= w_funct3;
            r_offset     <= w_offset;
            r_result     <= '0;
            r_result_err <= 1'b0;
            if (w_is_mem && !w_f3_ok) begin
              r_result_err <= 1'b1;
              r_state      <= ST_DONE;
            end else if (w_is_mem && w_misaligned) begin
              r_result     <= rdata_i;
              r_result_err <= 1'b1;
              r_state      <= ST_DONE;
            end else if (w_is_mem) begin
              r_req   <= 1'b1;
              r_we    <= w_is_store;
              r_addr  <= {rdata_i[63:3], 3'b000};
              r_wdata <= w_is_store ? w_wdata : '0;
              r_wstrb <= w_is_store ? w_wstrb : '0;
              r_cnt   <= '0;
              r_state <= ST_ACCESS;
            end else begin
              r_result <= rdata_i;
              r_state  <= ST_DONE;
            end
          end
        end
        ST_ACCESS: begin
          // A same-cycle ack wins over the timeout.
          if (dmem.dmem_ack_i || w_timeout) begin
            r_req        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_result     <= (dmem.dmem_ack_i && r_is_load) ? w_load_data : '0;
            r_result_err <= !dmem.dmem_ack_i;
            r_state      <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 64'd1;
          end
        end
        ST_DONE: begin
          r_busy     <= 1'b0;
          r_pc_o     <= r_pc;
          r_inst_o   <= r_inst;
          r_wb_data  <= r_result;
          r_wb_valid <= 1'b1;
          r_err      <= r_result_err;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy_o            = r_busy;
  assign dmem.dmem_req_o   = r_req;
  assign dmem.dmem_we_o    = r_we;
  assign dmem.dmem_addr_o  = r_addr;
  assign dmem.dmem_wdata_o = r_wdata;
  assign dmem.dmem_wstrb_o = r_wstrb;
  assign pc_o              = r_pc_o;
  assign inst_o            = r_inst_o;
  assign wb_data_o         = r_wb_data;
  assign wb_valid_o        = r_wb_valid;
  assign err_o             = r_err;

endmodule
